trigger_window_reader: RTL and testbench
========================================

# trigger_window_reader

Capture-side reader that pairs with the trigger comparator in the sample-generator path. It writes the incoming sample stream into an internal circular buffer and, on a trigger strobe, freezes a window of pre-trigger and post-trigger samples. It then streams that window out as one AXI-Stream frame with `tlast`. It reports the buffer index of the trigger sample so DMA software can align the frame.

## Interface
- `DATA_WIDTH`, 16, sample width (signed, passed through unmodified)
- `ADDR_WIDTH`, 10, buffer index width; depth = 2^ADDR_WIDTH
- `PRE_SAMPLES`, 256, samples before the trigger sample; must be 1..WINDOW-1
- `WINDOW`, 512, total frame length including trigger sample; must be ≤ 2^ADDR_WIDTH

- `clk` in 1 — single clock
- `rst_n` in 1 — reset, asynchronous, active-low
- `in_data_valid` in 1 — sample strobe
- `in_data` in DATA_WIDTH — sample
- `trigger_in` in 1 — trigger; qualified by `in_data_valid` in the same cycle
- `arm` in 1 — one-cycle start request
- `m_axis_tdata` out DATA_WIDTH — frame sample
- `m_axis_tvalid` out 1 — beat valid
- `m_axis_tready` in 1 — downstream ready
- `m_axis_tlast` out 1 — last beat of frame
- `trig_offset` out ADDR_WIDTH — buffer index of the trigger sample
- `busy` out 1 — state ≠ IDLE
- `armed` out 1 — state == ARMED
- `done` out 1 — one-cycle pulse after the final beat is accepted

## Operation
- States: IDLE, FILL, ARMED, POST, READ.
- Writes occur only in FILL, ARMED and POST, on `in_data_valid`.
  - Each write goes to `wptr`, then `wptr` increments mod 2^ADDR_WIDTH.
  - Samples arriving in IDLE or READ are dropped.
- IDLE:
  - `arm`=1 clears the fill counter → FILL.
  - `wptr` is not reset.
- FILL:
  - Counts writes.
  - When the PRE_SAMPLES-th write occurs → ARMED.
  - `trigger_in` is ignored.
- ARMED, on `in_data_valid && trigger_in`:
  - The sample is written.
  - `trig_offset` ← `wptr`.
  - `start_ptr` ← (`wptr` − PRE_SAMPLES) mod depth.
  - Post counter ← WINDOW − PRE_SAMPLES − 1.
  - If that count is 0 → READ, else → POST.
- POST:
  - Decrements on each write.
  - The write that brings the counter to 0 → READ.
- READ:
  - Emits exactly WINDOW beats from `start_ptr` upward, wrapping mod depth.
  - `m_axis_tlast`=1 on beat WINDOW−1 only.
  - After the final handshake → IDLE and `done` pulses.
- `arm` outside IDLE is ignored.
- `trigger_in` outside ARMED is ignored.
- `trig_offset` holds its value until the next accepted trigger.
- Simultaneous `arm` and `trigger_in` in IDLE: only `arm` acts.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - State IDLE; `wptr`, `start_ptr` and counters = 0.
  - All outputs = 0, including `m_axis_tvalid`, `m_axis_tlast`, `done` and `trig_offset`.
- Buffer is synchronous-read RAM with 1-cycle read latency.
- First `m_axis_tvalid` rises 2 cycles after the clock edge that writes the last window sample.
- With `m_axis_tready` held high, beats are back-to-back: one per cycle, WINDOW cycles.
- AXI-Stream rules:
  - Once asserted, `m_axis_tvalid` stays high until handshake.
  - `tdata` and `tlast` stay stable while `tvalid && !tready`.
  - `tvalid` never depends combinationally on `tready`.
- `done` is asserted the cycle after the final handshake; `busy` falls in that same cycle.
- `armed` is registered and rises the cycle after the PRE_SAMPLES-th write.
- Reset mid-frame: `m_axis_tvalid` drops immediately; no partial `tlast` is produced.

## Configuration
- `TRIGGER_WINDOW_AUTO_REARM_EN` defined:
  - On frame completion the FSM goes to FILL instead of IDLE, with the fill counter cleared.
  - `done` still pulses; `arm` is not required for subsequent frames.
- Not defined: return to IDLE; each frame requires an `arm` pulse.

## Test plan
Setup: DATA_WIDTH=16, ADDR_WIDTH=4, PRE_SAMPLES=4, WINDOW=8. Input is a ramp 0,1,2,… with `in_data_valid` held at 1 and `arm` pulsed at start.
- Reset: drop `rst_n` asynchronously mid-cycle → all outputs 0 immediately, `busy`=0.
- Basic: trigger on sample 10 → frame 6,7,8,9,10,11,12,13; `tlast` on 13; `trig_offset`=10; `done` pulses once.
- Early trigger: trigger on sample 2 (FILL) ignored; trigger on sample 7 → frame 3..10, `trig_offset`=7.
- Wrap: ramp starts at 0, trigger on sample 18 (`wptr`=2) → frame 14..21; `start_ptr`=14, `trig_offset`=2.
- Backpressure: `m_axis_tready` pattern 1,0,1,0,… → same 8 values in order; `tdata` stable on every stalled cycle.
- Reset mid-READ: assert `rst_n`=0 after beat 3 → `tvalid`=0; then re-`arm` and trigger on sample 20 → full 8-beat frame 16..23.

Source files
------------

// File: rtl/trigger_window_reader.sv
// trigger_window_reader
// Writes the sample stream into a circular buffer, freezes a window of
// PRE_SAMPLES pre-trigger samples plus the trigger and post-trigger samples,
// then streams the window out as one AXI-Stream frame terminated by tlast.
// Optional feature macro: TRIGGER_WINDOW_AUTO_REARM_EN (re-enter FILL after
// each frame instead of waiting in IDLE for arm).
//
// AXI-Stream handshake: a beat transfers on a rising edge where
// m_axis_tvalid && m_axis_tready. tvalid, tdata and tlast come straight from
// registers; once tvalid is high it and the beat contents hold until that
// transfer, and tvalid never depends combinationally on tready.
module trigger_window_reader #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 10,
    parameter int PRE_SAMPLES = 256,
    parameter int WINDOW      = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_data_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  trigger_in,
    input  logic                  arm,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ADDR_WIDTH-1:0] trig_offset,
    output logic                  busy,
    output logic                  armed,
    output logic                  done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0]         PRE_LAST = CW'(PRE_SAMPLES - 1);
    localparam logic [CW-1:0]         POST_CNT = CW'(WINDOW - PRE_SAMPLES - 1);
    localparam logic [CW-1:0]         WIN_CNT  = CW'(WINDOW);
    localparam logic [ADDR_WIDTH-1:0] PRE_OFS  = ADDR_WIDTH'(PRE_SAMPLES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        READ  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0]   start_ptr_q, start_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0]   trig_offset_q, trig_offset_d;
    logic [CW-1:0]           fill_cnt_q, fill_cnt_d;
    logic [CW-1:0]           post_cnt_q, post_cnt_d;
    logic [CW-1:0]           rd_cnt_q, rd_cnt_d;
    logic                    busy_q, armed_q, done_q;

    // Read pipeline: stage 1 is the RAM output register, stage 2 the AXIS output.
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   s1_data_q;
    logic                    s1_valid_q, s1_last_q;
    logic [DATA_WIDTH-1:0]   tdata_q;
    logic                    tvalid_q, tlast_q;

    logic wr_en, hs, s2_load, rd_en, final_hs;

    // Datapath strobes: buffer write, output handshake and read issue.
    always_comb begin
        wr_en    = in_data_valid && ((state_q == FILL) || (state_q == ARMED) || (state_q == POST));
        hs       = tvalid_q && m_axis_tready;
        final_hs = hs && tlast_q;
        s2_load  = !tvalid_q || m_axis_tready;
        rd_en    = (state_q == READ) && (rd_cnt_q != '0) && (!s1_valid_q || s2_load);
        wptr_d   = wr_en ? wptr_q + 1'b1 : wptr_q;
    end

    // Next-state and counter logic for the capture FSM.
    always_comb begin
        state_d       = state_q;
        fill_cnt_d    = fill_cnt_q;
        post_cnt_d    = post_cnt_q;
        start_ptr_d   = start_ptr_q;
        trig_offset_d = trig_offset_q;
        rd_ptr_d      = rd_ptr_q;
        rd_cnt_d      = rd_cnt_q;
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rd_cnt_d = rd_cnt_q - 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (arm) begin
                    fill_cnt_d = '0;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (in_data_valid) begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (fill_cnt_q == PRE_LAST) begin
                        state_d = ARMED;
                    end
                end
            end
            ARMED: begin
                if (in_data_valid && trigger_in) begin
                    trig_offset_d = wptr_q;
                    start_ptr_d   = wptr_q - PRE_OFS;
                    post_cnt_d    = POST_CNT;
                    if (POST_CNT == '0) begin
                        // Trigger is the last window sample: read starts at once.
                        state_d  = READ;
                        rd_ptr_d = wptr_q - PRE_OFS;
                        rd_cnt_d = WIN_CNT;
                    end else begin
                        state_d = POST;
                    end
                end
            end
            POST: begin
                if (in_data_valid) begin
                    post_cnt_d = post_cnt_q - 1'b1;
                    if (post_cnt_q == CW'(1)) begin
                        state_d  = READ;
                        rd_ptr_d = start_ptr_q;
                        rd_cnt_d = WIN_CNT;
                    end
                end
            end
            READ: begin
                if (final_hs) begin
`ifdef TRIGGER_WINDOW_AUTO_REARM_EN
                    fill_cnt_d = '0;
                    state_d    = FILL;
`else
                    state_d    = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, pointers, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wptr_q        <= '0;
            start_ptr_q   <= '0;
            rd_ptr_q      <= '0;
            trig_offset_q <= '0;
            fill_cnt_q    <= '0;
            post_cnt_q    <= '0;
            rd_cnt_q      <= '0;
            busy_q        <= 1'b0;
            armed_q       <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            start_ptr_q   <= start_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            trig_offset_q <= trig_offset_d;
            fill_cnt_q    <= fill_cnt_d;
            post_cnt_q    <= post_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            busy_q        <= (state_d != IDLE);
            armed_q       <= (state_d == ARMED);
            done_q        <= final_hs;
        end
    end

    // Sample buffer: synchronous write and 1-cycle registered read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= in_data;
        end
        if (rd_en) begin
            s1_data_q <= mem_q[rd_ptr_q];
        end
    end

    // Read pipeline occupancy and the AXI-Stream output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
        end else begin
            if (rd_en) begin
                s1_valid_q <= 1'b1;
                s1_last_q  <= (rd_cnt_q == CW'(1));
            end else if (s2_load) begin
                s1_valid_q <= 1'b0;
            end
            if (s2_load) begin
                tvalid_q <= s1_valid_q;
                tlast_q  <= s1_valid_q && s1_last_q;
                if (s1_valid_q) begin
                    tdata_q <= s1_data_q;
                end
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign trig_offset   = trig_offset_q;
    assign busy          = busy_q;
    assign armed         = armed_q;
    assign done          = done_q;

endmodule

// File: tb/tb_trigger_window_reader.sv
// Directed bench for trigger_window_reader with a small 16-entry buffer and
// an 8-sample window (4 pre-trigger samples). Inputs change on the falling
// edge; outputs are observed on the falling edge.
module tb_trigger_window_reader;

    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int PRE = 4;
    localparam int WIN = 8;

    logic          clk;
    logic          rst_n;
    logic          in_data_valid;
    logic [DW-1:0] in_data;
    logic          trigger_in;
    logic          arm;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [AW-1:0] trig_offset;
    logic          busy;
    logic          armed;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;
    int ramp  = 0;
    logic [DW-1:0] exp_q[$];

    trigger_window_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .PRE_SAMPLES(PRE),
        .WINDOW     (WIN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data_valid(in_data_valid),
        .in_data      (in_data),
        .trigger_in   (trigger_in),
        .arm          (arm),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .trig_offset  (trig_offset),
        .busy         (busy),
        .armed        (armed),
        .done         (done)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        check({tag, "_tlast"},  32'(m_axis_tlast),  32'd0);
        check({tag, "_tdata"},  32'(m_axis_tdata),  32'd0);
        check({tag, "_toff"},   32'(trig_offset),   32'd0);
        check({tag, "_busy"},   32'(busy),          32'd0);
        check({tag, "_armed"},  32'(armed),         32'd0);
        check({tag, "_done"},   32'(done),          32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        in_data_valid = 1'b0;
        trigger_in    = 1'b0;
        arm           = 1'b0;
        m_axis_tready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ramp  = 0;
    endtask

    // Pulse arm with no valid sample; the ramp starts on the next cycle.
    task automatic do_arm();
        @(negedge clk);
        arm           = 1'b1;
        in_data_valid = 1'b0;
        trigger_in    = 1'b0;
    endtask

    task automatic load_expected(input int first);
        exp_q.delete();
        for (int i = 0; i < WIN; i++) exp_q.push_back(DW'(first + i));
    endtask

    // Drive the ramp, trigger on trig_val (and optionally early_val), and
    // collect beats until stop_after beats are accepted or the budget runs out.
    task automatic run_frame(input int trig_val, input int early_val, input int bp_mode,
                             input int stop_after, input int exp_first_valid);
        int  beats;
        int  first_valid;
        bit  stalled;
        bit  gave_up;
        beats       = 0;
        first_valid = -1;
        stalled     = 1'b0;
        gave_up     = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            arm = 1'b0;
            if (cyc == PRE - 1) check("armed_before", 32'(armed), 32'd0);
            if (cyc == PRE)     check("armed_rise",   32'(armed), 32'd1);
            if (stalled) check("stall_tvalid_held", 32'(m_axis_tvalid), 32'd1);
            stalled = 1'b0;
            if (m_axis_tvalid && first_valid < 0) begin
                first_valid = cyc;
                check("first_tvalid_cycle", 32'(cyc), 32'(exp_first_valid));
                check("busy_in_read", 32'(busy), 32'd1);
            end
            m_axis_tready = (bp_mode != 0) ? ((cyc % 2) == 0) : 1'b1;
            if (m_axis_tvalid) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 32'd1, 32'd0);
                end else begin
                    check("tdata", 32'(m_axis_tdata), 32'(exp_q[0]));
                    check("tlast", 32'(m_axis_tlast), 32'(beats == WIN - 1));
                    if (m_axis_tready) begin
                        void'(exp_q.pop_front());
                        beats++;
                    end else begin
                        stalled = 1'b1;
                    end
                end
            end
            in_data_valid = 1'b1;
            in_data       = DW'(ramp);
            trigger_in    = (ramp == trig_val) || (ramp == early_val);
            ramp++;
            if (beats >= stop_after) break;
            if (cyc == 199) gave_up = 1'b1;
        end
        if (gave_up) check("beat_budget", 32'(beats), 32'(stop_after));
        trigger_in = 1'b0;
    endtask

    // After the final handshake: one done pulse, busy low, no further beats.
    task automatic finish_frame(input int exp_off);
        @(negedge clk);
        in_data_valid = 1'b0;
        check("done_pulse",   32'(done),          32'd1);
        check("busy_fall",    32'(busy),          32'd0);
        check("tvalid_after", 32'(m_axis_tvalid), 32'd0);
        check("trig_offset",  32'(trig_offset),   32'(exp_off));
        @(negedge clk);
        check("done_single",  32'(done),          32'd0);
        check("offset_hold",  32'(trig_offset),   32'(exp_off));
    endtask

    initial begin
        rst_n         = 1'b1;
        in_data_valid = 1'b0;
        in_data       = '0;
        trigger_in    = 1'b0;
        arm           = 1'b0;
        m_axis_tready = 1'b1;

        // Power-on: asynchronous reset mid-cycle.
        #3 rst_n = 1'b0;
        #1 check_all_zero("por");
        do_reset();

        // Basic: trigger on sample 10 -> 6..13, offset 10.
        load_expected(6);
        do_arm();
        run_frame(10, -1, 0, WIN, 16);
        finish_frame(10);

        // Early trigger in FILL ignored; trigger on 7 -> 3..10.
        do_reset();
        check("reset_offset", 32'(trig_offset), 32'd0);
        load_expected(3);
        do_arm();
        run_frame(7, 2, 0, WIN, 13);
        finish_frame(7);

        // Wrap: trigger on 18 (wptr 2) -> 14..21.
        do_reset();
        load_expected(14);
        do_arm();
        run_frame(18, -1, 0, WIN, 24);
        finish_frame(2);

        // Backpressure: alternating tready, same frame as basic.
        do_reset();
        load_expected(6);
        do_arm();
        run_frame(10, -1, 1, WIN, 16);
        finish_frame(10);

        // Reset mid-READ after beat 3, then a fresh frame.
        do_reset();
        load_expected(6);
        do_arm();
        run_frame(10, -1, 0, 4, 16);
        @(posedge clk);
        #2;
        check("pre_reset_tvalid", 32'(m_axis_tvalid), 32'd1);
        rst_n = 1'b0;
        #1 check_all_zero("mid_read_reset");
        do_reset();
        load_expected(16);
        do_arm();
        run_frame(20, -1, 0, WIN, 26);
        finish_frame(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
